// File: rtl/instr_sequencer_pkg.sv
// Shared constants and types for the instruction sequencer and its neighbours.
// Instruction format, opcode field bounds and the FSM state encoding live here.
package instr_sequencer_pkg;

  localparam int unsigned InstrWidth = 20;
  localparam int unsigned OpcodeMsb  = 19;
  localparam int unsigned OpcodeLsb  = 16;

  localparam logic [OpcodeMsb-OpcodeLsb:0] HaltOpcode = 4'hF;
  localparam logic [InstrWidth-1:0]        NopInstr   = 20'h00000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic logic is_halt_word(input logic [InstrWidth-1:0] word);
    return word[OpcodeMsb:OpcodeLsb] == HaltOpcode;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Host load/control and CPU issue signals of the instruction sequencer.
// master = host/CPU side, slave = sequencer side.
interface instr_sequencer_if #(
  parameter int unsigned PcBits     = 5,
  parameter int unsigned InstrWidth = instr_sequencer_pkg::InstrWidth
);
  logic                  load_valid;
  logic                  load_ready;
  logic [PcBits-1:0]     load_addr;
  logic [InstrWidth-1:0] load_data;
  logic                  start;
  logic                  stop;
  logic                  step;
  logic [InstrWidth-1:0] instruction;
  logic                  instr_valid;
  logic [PcBits-1:0]     pc;
  logic                  busy;
  logic                  done;

  modport master (
    output load_valid, load_addr, load_data, start, stop, step,
    input  load_ready, instruction, instr_valid, pc, busy, done
  );

  modport slave (
    input  load_valid, load_addr, load_data, start, stop, step,
    output load_ready, instruction, instr_valid, pc, busy, done
  );
endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: synchronous write, combinational read.
// Contents are never cleared by reset.
module instr_sequencer_prog_mem
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned AddrBits  = 5,
  parameter int unsigned DataWidth = InstrWidth
) (
  input  logic                 clk,
  input  logic                 wen,
  input  logic [AddrBits-1:0]  waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [AddrBits-1:0]  raddr,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem [2**AddrBits];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: loadable program memory, PC and a run/pause/step FSM
// feeding one registered instruction per cycle to simple_cpu.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned PcBits = 5,
  parameter bit          Wrap   = 1'b0
) (
  input logic              clk,
  input logic              rst,
  instr_sequencer_if.slave bus
);

  localparam logic [PcBits-1:0] PcLast = {PcBits{1'b1}};

  state_e                state_q;
  logic [PcBits-1:0]     pc_q;
  logic [InstrWidth-1:0] instr_q;
  logic                  valid_q;

  logic                  load_ready;
  logic                  wen;
  logic [InstrWidth-1:0] rdata;
  logic                  issue;

  assign load_ready = (state_q == StIdle) || (state_q == StDone);
  // No write is taken on a reset edge.
  assign wen        = bus.load_valid && load_ready && rst;

  // stop beats start/step; a start in PAUSE alone only resumes, it does not issue.
  assign issue = ((state_q == StRun) && !bus.stop) ||
                 ((state_q == StPause) && !bus.stop && bus.step);

  instr_sequencer_prog_mem #(
    .AddrBits (PcBits),
    .DataWidth(InstrWidth)
  ) u_prog_mem (
    .clk  (clk),
    .wen  (wen),
    .waddr(bus.load_addr),
    .wdata(bus.load_data),
    .raddr(pc_q),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= NopInstr;
      valid_q <= 1'b0;
    end else begin
      instr_q <= NopInstr;
      valid_q <= 1'b0;

      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start && !bus.load_valid) begin
            state_q <= StRun;
            pc_q    <= '0;
          end
        end
        StRun: begin
          if (bus.stop) begin
            state_q <= StPause;
          end
        end
        StPause: begin
          if (!bus.stop && bus.start) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Issue outcome overrides the plain transition above.
      if (issue) begin
        if (is_halt_word(rdata)) begin
          state_q <= StDone;
        end else begin
          instr_q <= rdata;
          valid_q <= 1'b1;
          pc_q    <= pc_q + 1'b1;
          if ((pc_q == PcLast) && !Wrap) begin
            state_q <= StDone;
          end
        end
      end
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = (state_q == StRun) || (state_q == StPause);
  assign bus.done        = (state_q == StDone);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a WRAP=0 and a WRAP=1 instance share stimulus and are
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_instr_sequencer;

  localparam int Depth = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [19:0] load_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        step = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  instr_sequencer_if #(.PcBits(5), .InstrWidth(20)) bus0 ();
  instr_sequencer_if #(.PcBits(5), .InstrWidth(20)) bus1 ();

  always_comb begin
    bus0.load_valid = load_valid;
    bus0.load_addr  = load_addr;
    bus0.load_data  = load_data;
    bus0.start      = start;
    bus0.stop       = stop;
    bus0.step       = step;
    bus1.load_valid = load_valid;
    bus1.load_addr  = load_addr;
    bus1.load_data  = load_data;
    bus1.start      = start;
    bus1.stop       = stop;
    bus1.step       = step;
  end

  instr_sequencer #(.PcBits(5), .Wrap(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  instr_sequencer #(.PcBits(5), .Wrap(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (one per instance) ----------------
  localparam int ModeIdle = 0, ModeRun = 1, ModePause = 2, ModeDone = 3;

  logic [19:0] m_mem [2][Depth];
  int          m_mode [2];
  int          m_pc [2];
  logic [19:0] m_out [2];
  logic        m_v [2];

  always @(posedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (!rst) begin
        m_mode[w] = ModeIdle;
        m_pc[w]   = 0;
        m_out[w]  = 20'h0;
        m_v[w]    = 1'b0;
      end else begin
        automatic bit   idle_like = (m_mode[w] == ModeIdle) || (m_mode[w] == ModeDone);
        automatic bit   go = 1'b0;
        automatic logic [19:0] word;
        m_out[w] = 20'h0;
        m_v[w]   = 1'b0;
        if (load_valid && idle_like) m_mem[w][load_addr] = load_data;
        if (idle_like) begin
          if (start && !load_valid) begin
            m_mode[w] = ModeRun;
            m_pc[w]   = 0;
          end
        end else if (m_mode[w] == ModeRun) begin
          if (stop) m_mode[w] = ModePause;
          else go = 1'b1;
        end else if (!stop) begin
          if (start) m_mode[w] = ModeRun;
          if (step) go = 1'b1;
        end
        if (go) begin
          word = m_mem[w][m_pc[w]];
          if (word[19:16] == 4'hF) begin
            m_mode[w] = ModeDone;
          end else begin
            m_out[w] = word;
            m_v[w]   = 1'b1;
            if (m_pc[w] == Depth - 1 && w == 0) m_mode[w] = ModeDone;
            m_pc[w] = (m_pc[w] + 1) % Depth;
          end
        end
      end
    end
  end

  task automatic cmp_one(input int w, input logic [19:0] ins, input logic v, input logic [4:0] pc,
                         input logic busy, input logic done, input logic ready);
    check($sformatf("dut%0d.instruction", w), 32'(ins), 32'(m_out[w]));
    check($sformatf("dut%0d.instr_valid", w), 32'(v), 32'(m_v[w]));
    check($sformatf("dut%0d.pc", w), 32'(pc), 32'(m_pc[w]));
    check($sformatf("dut%0d.busy", w), 32'(busy),
          32'(m_mode[w] == ModeRun || m_mode[w] == ModePause));
    check($sformatf("dut%0d.done", w), 32'(done), 32'(m_mode[w] == ModeDone));
    check($sformatf("dut%0d.load_ready", w), 32'(ready),
          32'(m_mode[w] == ModeIdle || m_mode[w] == ModeDone));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_one(0, bus0.instruction, bus0.instr_valid, bus0.pc, bus0.busy, bus0.done,
              bus0.load_ready);
      cmp_one(1, bus1.instruction, bus1.instr_valid, bus1.pc, bus1.busy, bus1.done,
              bus1.load_ready);
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [4:0] a, input logic [19:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    cyc();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done0(input string name);
    int guard = 0;
    while (!bus0.done && guard < 80) begin
      cyc();
      guard++;
    end
    check(name, 32'(bus0.done), 32'd1);
  endtask

  logic [19:0] fill [Depth];

  initial begin
    int cnt;
    int guard;

    // Reset
    rst = 1'b0;
    cyc();
    cyc();
    chk_en = 1'b1;
    check("reset instruction", 32'(bus0.instruction), 32'h0);
    check("reset instr_valid", 32'(bus0.instr_valid), 32'h0);
    check("reset pc", 32'(bus0.pc), 32'h0);
    check("reset load_ready", 32'(bus0.load_ready), 32'h1);
    rst = 1'b1;

    for (int i = 0; i < Depth; i++) load(5'(i), 20'h1_0000 | 20'(i));
    load(5'd0, 20'h1_0203);
    load(5'd1, 20'h2_0405);
    load(5'd2, 20'hF_0000);

    // Run to halt; a load attempt while running must be rejected
    pulse_start();
    check("run busy", 32'(bus0.busy), 32'h1);
    load_valid = 1'b1;
    load_addr  = 5'd0;
    load_data  = 20'h5_5555;
    cyc();
    check("first word", 32'(bus0.instruction), 32'h1_0203);
    check("first valid", 32'(bus0.instr_valid), 32'h1);
    check("load_ready in run", 32'(bus0.load_ready), 32'h0);
    cyc();
    check("second word", 32'(bus0.instruction), 32'h2_0405);
    load_valid = 1'b0;
    cyc();
    check("halt nop", 32'(bus0.instruction), 32'h0);
    check("halt done", 32'(bus0.done), 32'h1);
    check("halt pc", 32'(bus0.pc), 32'h2);
    pulse_start();
    cyc();
    check("rerun word unchanged", 32'(bus0.instruction), 32'h1_0203);
    wait_done0("rerun done");

    // Pause / step
    for (int i = 0; i < 8; i++) load(5'(i), 20'h3_00A0 + 20'(i));
    load(5'd8, 20'hF_0001);
    pulse_start();
    cyc();
    cyc();
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("pause pc", 32'(bus0.pc), 32'h3);
    check("pause busy", 32'(bus0.busy), 32'h1);
    check("pause nop", 32'(bus0.instr_valid), 32'h0);
    stop = 1'b1;
    step = 1'b1;
    cyc();
    stop = 1'b0;
    step = 1'b0;
    check("stop+step no issue", 32'(bus0.instr_valid), 32'h0);
    step = 1'b1;
    cyc();
    step = 1'b0;
    check("step1 word", 32'(bus0.instruction), 32'h3_00A3);
    cyc();
    check("after step nop", 32'(bus0.instr_valid), 32'h0);
    step = 1'b1;
    cyc();
    step = 1'b0;
    check("step2 word", 32'(bus0.instruction), 32'h3_00A4);
    pulse_start();
    cyc();
    check("resume word", 32'(bus0.instruction), 32'h3_00A5);
    wait_done0("pause prog done");

    // start + load in the same cycle: the load wins
    start      = 1'b1;
    load_valid = 1'b1;
    load_addr  = 5'd0;
    load_data  = 20'h2_BEEF;
    cyc();
    start      = 1'b0;
    load_valid = 1'b0;
    check("start+load not busy", 32'(bus0.busy), 32'h0);
    pulse_start();
    cyc();
    check("start+load word written", 32'(bus0.instruction), 32'h2_BEEF);
    wait_done0("start+load prog done");

    // End of memory
    for (int i = 0; i < Depth; i++) begin
      fill[i] = 20'h1_0000 | 20'(i * 7 + 1);
      load(5'(i), fill[i]);
    end
    pulse_start();
    cnt   = 0;
    guard = 0;
    while (guard < 64) begin
      cyc();
      guard++;
      if (bus0.instr_valid) cnt++;
      if (bus0.done) break;
    end
    check("wrap0 issue count", 32'(cnt), 32'd32);
    check("wrap0 done", 32'(bus0.done), 32'h1);
    check("wrap0 pc", 32'(bus0.pc), 32'h0);
    check("wrap1 last word", 32'(bus1.instruction), 32'(fill[31]));
    cyc();
    check("wrap1 word0", 32'(bus1.instruction), 32'(fill[0]));
    check("wrap1 busy", 32'(bus1.busy), 32'h1);

    // Reset mid-run at pc 4
    pulse_start();
    guard = 0;
    while (bus0.pc != 5'd4 && guard < 20) begin
      cyc();
      guard++;
    end
    check("reach pc4", 32'(bus0.pc), 32'h4);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check("midrun rst pc", 32'(bus0.pc), 32'h0);
    check("midrun rst busy", 32'(bus0.busy), 32'h0);
    check("midrun rst nop", 32'(bus0.instruction), 32'h0);
    pulse_start();
    cyc();
    check("post rst word0 dut0", 32'(bus0.instruction), 32'(fill[0]));
    check("post rst word0 dut1", 32'(bus1.instruction), 32'(fill[0]));

    // Random phase from a clean, fully loaded memory
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    for (int i = 0; i < Depth; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      load(5'(i), {op, 16'($urandom)});
    end
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] op;
      op         = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      load_valid = ($urandom_range(0, 3) == 0);
      load_addr  = 5'($urandom);
      load_data  = {op, 16'($urandom)};
      start      = ($urandom_range(0, 15) == 0);
      stop       = ($urandom_range(0, 15) == 0);
      step       = ($urandom_range(0, 7) == 0) && !start;
      rst        = ($urandom_range(0, 199) != 0);
      cyc();
    end
    load_valid = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    step       = 1'b0;
    rst        = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction-side counterpart to simple_cpu. simple_cpu consumes one 20-bit instruction per clock; this block supplies it.
- Holds a loadable program memory and a program counter (PC). Issues one instruction per cycle while running.
- Inserts a NOP bubble whenever it is not issuing.
- Supports run, pause, single-step and halt-on-opcode. Sits between the test/host loader and simple_cpu.instruction.

Parameters:
- INSTR_WIDTH, 20, instruction width; matches simple_cpu.
- PC_BITS, 5, PC width; program depth = 2**PC_BITS = 32 words.
- HALT_OPCODE, 4'hF, value of instr[19:16] that terminates the program.
- NOP_INSTR, 20'h00000, bubble word driven when not issuing.
- WRAP, 0, 1 = PC wraps to 0 after the last word; 0 = finish at the last word.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- load_valid  in  1  host write request.
- load_ready  out  1  high when a write is accepted (IDLE or DONE).
- load_addr  in  PC_BITS  program word address.
- load_data  in  INSTR_WIDTH  program word.
- start  in  1  pulse: begin or resume execution.
- stop  in  1  pulse: pause execution.
- step  in  1  pulse: issue exactly one instruction while paused.
- instruction  out  INSTR_WIDTH  to simple_cpu.instruction; registered.
- instr_valid  out  1  high when instruction is a real program word.
- pc  out  PC_BITS  address of the next word to fetch.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst == 0 at a clock edge):
  - state = IDLE, pc = 0, instruction = NOP_INSTR, instr_valid = 0, done = 0, busy = 0, load_ready = 1.
  - Memory contents are retained, not cleared.
  - Reset mid-RUN aborts on that same edge.
- States: IDLE, RUN, PAUSE, DONE.
- Load:
  - A write occurs when load_valid && load_ready: mem[load_addr] <= load_data.
  - load_ready = 1 in IDLE/DONE, 0 otherwise. Writes are ignored while busy.
- IDLE/DONE -> RUN on start: pc <= 0, done <= 0.
  - If load_valid is high in the same cycle, the load wins and start is ignored.
- Issue cycle (RUN, or PAUSE with step):
  - w = mem[pc].
  - If w[19:16] == HALT_OPCODE: instruction <= NOP_INSTR, instr_valid <= 0, state -> DONE. pc holds the HALT address. The HALT word is never issued.
  - Otherwise: instruction <= w, instr_valid <= 1, pc <= pc + 1 (modulo depth).
- Latency: the word at address a appears on instruction exactly one cycle after the issue cycle in which pc == a.
  - First program word appears the cycle after the start pulse is sampled, plus one.
  - I.e. start at cycle 0 -> RUN at cycle 1 -> mem[0] on instruction at cycle 2.
- End of memory (issuing pc == 2**PC_BITS-1, non-halt word):
  - WRAP = 0: the word is issued, then state -> DONE, pc wraps to 0.
  - WRAP = 1: pc -> 0 and RUN continues.
- RUN -> PAUSE on stop. A stop sampled in RUN suppresses that cycle's issue.
  - stop beats start and step in the same cycle.
- PAUSE:
  - instruction = NOP_INSTR, instr_valid = 0, except in the cycle after a step issue.
  - start -> RUN; the fetch resumes at the current pc.
  - start and step together: start wins, one issue occurs.
- Non-issue cycles in every state drive NOP_INSTR with instr_valid = 0.
- busy = (state == RUN || state == PAUSE); done = (state == DONE). Both are registered with the state.
- start/stop/step in any state other than those listed above are ignored.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding (IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3);
  - INSTR_WIDTH, HALT_OPCODE, NOP_INSTR constants;
  - opcode field slice bounds [19:16], shared with the CU.
- One sub-module: prog_mem.
  - Synchronous-write, combinational-read array of 2**PC_BITS x INSTR_WIDTH.
  - Ports: clk, wen, waddr, wdata, raddr, rdata.
- FSM, PC and output register stay in instr_sequencer.

Test Plan:
- Reset/load: hold rst = 0 for 2 cycles -> instruction = 20'h00000, instr_valid = 0, pc = 0, load_ready = 1. Then load addr 0..2 with 20'h1_0203, 20'h2_0405, 20'hF_0000.
- Run to halt: pulse start -> instruction = 20'h10203 then 20'h20405 on consecutive cycles with instr_valid = 1. Next cycle is NOP, done = 1, pc = 2. Load attempts during RUN are rejected (load_ready = 0, memory unchanged on readback).
- Pause/step: load 8 non-halt words, start, stop after 3 issued -> pc = 3, busy = 1, NOP output. Two step pulses -> exactly mem[3] then mem[4], each valid for one cycle. start -> resumes at mem[5].
- End of memory: fill all 32 words with non-halt opcode 4'h1, WRAP = 0 -> 32 valid issues, then done = 1, pc = 0. Rerun with WRAP = 1 -> word 31 followed by word 0, still busy.
- Priority: same-cycle start + load_valid in IDLE -> word written, state stays IDLE. Same-cycle stop + step in PAUSE -> no issue.
- Reset mid-run: assert rst = 0 during RUN at pc = 4 -> next edge state IDLE, pc = 0, NOP output. Memory still returns the loaded program on a new start.
